// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared widths, limits and FSM state type for bus_arbiter
package bus_arb_pkg;

  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 8;
  localparam int MAX_REQ = 4;
  localparam int IDX_W   = $clog2(MAX_REQ);

  typedef logic [IDX_W-1:0] req_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner select starting at rr
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           rr,
  output logic [NUM_REQ-1:0] win,
  output req_idx_t           idx
);

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  int   cand;
  logic found;

  // scan rr, rr+1, ... wrapping at NUM_REQ; first set request wins
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && |(req & (ONE << cand))) begin
        found = 1'b1;
        win   = ONE << cand;
        idx   = req_idx_t'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin memory bus arbiter; optional preemption via BUS_ARB_TIMEOUT_EN
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int HOLD_MAX = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        m_we,
  input  logic [NUM_REQ*ADDR_W-1:0] m_addr,
  input  logic [NUM_REQ*DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        inhibit,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [DATA_W-1:0]         m_rdata,
  output logic [NUM_REQ-1:0]        m_rvalid
);

  arb_state_t          state, state_n;
  logic [NUM_REQ-1:0]  gnt_n, win, rd_issue, rd_n;
  req_idx_t            rr, rr_n, win_idx;
  logic                we_n, sel_we, owner_req, timeout;
  logic [ADDR_W-1:0]   addr_n, sel_addr;
  logic [DATA_W-1:0]   wdata_n, sel_wdata;

  assign inhibit = ~gnt;
  assign m_rdata = mem_rdata;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req),
    .rr  (rr),
    .win (win),
    .idx (win_idx)
  );

  // route the current owner's bus signals; gnt is one-hot or zero
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = m_wdata[i*DATA_W +: DATA_W];
      end
    end
    sel_we    = |(m_we & gnt);
    owner_req = |(req & gnt);
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  // owned-cycle counter; sticks at HOLD_MAX-1 so a late competitor preempts at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               hold_cnt <= '0;
    else if (state != OWN)                    hold_cnt <= '0;
    else if (hold_cnt != 8'(HOLD_MAX - 1))    hold_cnt <= hold_cnt + 8'd1;
  end

  assign timeout = (hold_cnt == 8'(HOLD_MAX - 1)) && |(req & ~gnt);
`else
  logic unused_hold_max;
  assign unused_hold_max = (HOLD_MAX > 0);
  assign timeout = 1'b0;
`endif

  // next state, grant and bus register values; leaving OWN never forwards the owner's cycle
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    rr_n    = rr;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    rd_n    = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = OWN;
          gnt_n   = win;
          rr_n    = (win_idx == req_idx_t'(NUM_REQ - 1)) ? '0 : win_idx + req_idx_t'(1);
        end
      end
      OWN: begin
        if (!owner_req || timeout) begin
          state_n = TURN;
          gnt_n   = '0;
        end else begin
          we_n    = sel_we;
          addr_n  = sel_addr;
          wdata_n = sel_wdata;
          rd_n    = sel_we ? '0 : gnt;
        end
      end
      TURN: state_n = IDLE;
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // state and bus output registers; read-valid trails the registered address by one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= '0;
      rr        <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_issue  <= '0;
      m_rvalid  <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      rr        <= rr_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      rd_issue  <= rd_n;
      m_rvalid  <= rd_issue;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  m_we = '0;
  logic [33:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [7:0]  mem_rdata = '0;
  logic [1:0]  gnt, inhibit, m_rvalid;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata, m_rdata;

  int checks = 0;
  int failures = 0;
  logic sb_en = 1'b1;

  typedef struct { logic [16:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [1:0] who; logic [7:0] data; } rd_t;
  wr_t wq[$];
  rd_t rq[$];
  wr_t we_exp;
  rd_t re_exp;

  bus_arbiter #(.NUM_REQ(2), .HOLD_MAX(4)) dut (
    .clk(clk), .reset(reset), .req(req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .mem_rdata(mem_rdata), .gnt(gnt), .inhibit(inhibit),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [16:0] a);
    return a[7:0] ^ 8'h2C;
  endfunction

  always @(posedge clk) mem_rdata <= mem_f(mem_addr);

  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (inhibit !== ~gnt) begin
        failures++; $display("FAIL inhibit_inv inhibit=%b gnt=%b", inhibit, gnt);
      end
      checks++;
      if (!$onehot0(gnt)) begin
        failures++; $display("FAIL gnt_onehot gnt=%b", gnt);
      end
      if (sb_en && mem_we === 1'b1) begin
        checks++;
        if (wq.size() == 0) begin
          failures++; $display("FAIL wr_sb unexpected write addr=%h", mem_addr);
        end else begin
          we_exp = wq.pop_front();
          if (mem_addr !== we_exp.addr || mem_wdata !== we_exp.data) begin
            failures++;
            $display("FAIL wr_sb got addr=%h data=%h want addr=%h data=%h",
                     mem_addr, mem_wdata, we_exp.addr, we_exp.data);
          end
        end
      end
      if (sb_en && m_rvalid !== 2'b00) begin
        checks++;
        if (rq.size() == 0) begin
          failures++; $display("FAIL rd_sb unexpected rvalid=%b", m_rvalid);
        end else begin
          re_exp = rq.pop_front();
          if (m_rvalid !== re_exp.who || m_rdata !== re_exp.data) begin
            failures++;
            $display("FAIL rd_sb got rvalid=%b data=%h want rvalid=%b data=%h",
                     m_rvalid, m_rdata, re_exp.who, re_exp.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++; $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // owner o drives one bus cycle; expected output pushed only if it is granted now
  task automatic bus_cycle(input int o, input logic we, input logic [16:0] a, input logic [7:0] d);
    logic [1:0] oh;
    wr_t w;
    rd_t r;
    oh = '0; oh[o] = 1'b1;
    m_we[o] = we;
    m_addr[o*17 +: 17] = a;
    m_wdata[o*8 +: 8] = d;
    if (gnt[o] === 1'b1) begin
      if (we) begin w.addr = a; w.data = d; wq.push_back(w); end
      else begin r.who = oh; r.data = mem_f(a); rq.push_back(r); end
    end
    tick();
  endtask

  task automatic settle();
    req = '0; m_we = '0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    req = 2'b11;
    repeat (3) tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_inhibit", 32'(inhibit), 32'h3);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_rvalid", 32'(m_rvalid), 32'h0);
    reset = 1'b1; req = 2'b01;
    tick();
    chk("rst_first_gnt", 32'(gnt), 32'h1);
    chk("rst_first_inh", 32'(inhibit), 32'h2);
    settle();
  endtask

  task automatic test_write();
    req = 2'b01;
    tick();
    chk("wr_gnt", 32'(gnt), 32'h1);
    bus_cycle(0, 1'b1, 17'h1_0040, 8'hA5);
    chk("wr_mem_we", 32'(mem_we), 32'h1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h1_0040);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
    settle();
  endtask

  task automatic test_read();
    req = 2'b10;
    tick();
    chk("rd_gnt", 32'(gnt), 32'h2);
    bus_cycle(1, 1'b0, 17'h0_0010, 8'h00);
    req = 2'b00;
    tick();
    chk("rd_rvalid", 32'(m_rvalid), 32'h2);
    chk("rd_rdata", 32'(m_rdata), 32'h3C);
    chk("rd_turn_gnt", 32'(gnt), 32'h0);
    tick();
    chk("rd_rvalid_off", 32'(m_rvalid), 32'h0);
    settle();
  endtask

  task automatic test_handoff();
    req = 2'b10;
    tick();
    chk("ho_gnt", 32'(gnt), 32'h2);
    bus_cycle(1, 1'b1, 17'h0_1234, 8'h11);
    bus_cycle(1, 1'b1, 17'h0_1235, 8'h22);
    req = 2'b00; m_we[1] = 1'b1; m_addr[33:17] = 17'h1_FFFF; m_wdata[15:8] = 8'hEE;
    tick();
    chk("ho_turn_we", 32'(mem_we), 32'h0);
    chk("ho_turn_addr", 32'(mem_addr), 32'h0_1235);
    chk("ho_turn_gnt", 32'(gnt), 32'h0);
    tick();
    chk("ho_idle_we", 32'(mem_we), 32'h0);
    chk("ho_idle_addr", 32'(mem_addr), 32'h0_1235);
    settle();
  endtask

  task automatic test_round_robin();
    int owner;
    req = 2'b11;
    tick();
    chk("rr_first", 32'(gnt), 32'h1);
    for (int k = 0; k < 4; k++) begin
      owner = k % 2;
      bus_cycle(owner, 1'b1, 17'(17'h0_0100 + k), 8'(8'h30 + k));
      req[owner] = 1'b0;
      tick();
      chk("rr_turn", 32'(gnt), 32'h0);
      req[owner] = 1'b1;
      tick();
      chk("rr_idle", 32'(gnt), 32'h0);
      tick();
      chk("rr_next", 32'(gnt), (owner == 0) ? 32'h2 : 32'h1);
    end
    req = 2'b00;
    settle();
  endtask

  task automatic test_withdraw();
    req = 2'b01;
    tick();
    chk("wd_gnt", 32'(gnt), 32'h1);
    req[1] = 1'b1;
    bus_cycle(0, 1'b0, 17'h0_0A01, 8'h00);
    bus_cycle(0, 1'b0, 17'h0_0A02, 8'h00);
    req[1] = 1'b0;
    bus_cycle(0, 1'b0, 17'h0_0A03, 8'h00);
    req = 2'b00;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("wd_no_gnt", 32'(gnt), 32'h0);
    end
    settle();
  endtask

  task automatic test_timeout();
    int n;
    sb_en = 1'b0;
    m_we = '0;
    req = 2'b01;
    tick();
    chk("to_gnt", 32'(gnt), 32'h1);
    req = 2'b11;
    n = 0;
    while (gnt[0] === 1'b1 && n < 100) begin
      n++;
      tick();
    end
`ifdef BUS_ARB_TIMEOUT_EN
    chk("to_hold_cycles", 32'(n), 32'd4);
    chk("to_turn", 32'(gnt), 32'h0);
    tick();
    chk("to_idle", 32'(gnt), 32'h0);
    tick();
    chk("to_next", 32'(gnt), 32'h2);
`else
    chk("to_hold_cycles", 32'(n), 32'd100);
    chk("to_still_owner", 32'(gnt), 32'h1);
`endif
    settle();
    sb_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    req = 2'b01;
    tick();
    chk("rm_gnt", 32'(gnt), 32'h1);
    bus_cycle(0, 1'b1, 17'h0_0077, 8'h5C);
    bus_cycle(0, 1'b1, 17'h0_0078, 8'h5D);
    chk("rm_we_before", 32'(mem_we), 32'h1);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rm_we", 32'(mem_we), 32'h0);
    chk("rm_gnt_clr", 32'(gnt), 32'h0);
    chk("rm_inhibit", 32'(inhibit), 32'h3);
    chk("rm_addr", 32'(mem_addr), 32'h0);
    wq.delete();
    req = 2'b00; m_we = '0;
    tick();
    reset = 1'b1;
    tick();
    chk("rm_after_we", 32'(mem_we), 32'h0);
    chk("rm_after_gnt", 32'(gnt), 32'h0);
    settle();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_handoff();
    test_round_robin();
    test_withdraw();
    test_timeout();
    test_reset_mid();
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
